// File: rtl/pin_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pin_access_ctrl_pkg
//   Shared definitions for the PIN access controller: FSM state encoding and
//   small elaboration-time helpers for sizing counters.
// -----------------------------------------------------------------------------
package pin_access_ctrl_pkg;

  // Controller states; encodings are fixed so debug probes stay stable.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_GRANTED = 3'd2,
    ST_DENIED  = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

  // Larger of two integers, used to size the shared lockout/timeout counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/pin_access_ctrl_stb_edge_det.sv
// -----------------------------------------------------------------------------
// stb_edge_det
//   Rising-edge detector for a level keypad strobe. The strobe is registered
//   and a one-cycle event is flagged when the strobe is high now but was low
//   on the previous cycle. The event is deliberately combinational so it lines
//   up with the cycle in which the accompanying data is valid.
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   stb    in  level strobe from the keypad front end
//   evt    out one-cycle pulse on each 0->1 strobe transition
// -----------------------------------------------------------------------------
module stb_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  output logic evt
);

  logic stb_d_r;

  // Delayed copy of the strobe for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_d_r <= 1'b0;
    end else begin
      stb_d_r <= stb;
    end
  end

  assign evt = stb & ~stb_d_r;

endmodule

// File: rtl/pin_access_ctrl.sv
// -----------------------------------------------------------------------------
// pin_access_ctrl
//   PIN-entry access controller between the keypad front end and the door
//   actuation. Compares PIN_LEN digits against PIN_VALUE (digit 0 in the MS
//   slice), counts consecutive denials and enters a timed lockout after
//   MAX_TRIES of them.
//   Optional feature macro: PIN_TIMEOUT_EN -- when defined, a partially
//   entered PIN is denied after TIMEOUT_CYCLES cycles without a new digit.
// Ports
//   CLK              in  clock, rising edge
//   RESET            in  asynchronous active-low reset
//   SOLICITUD_ACCESO in  request: start or restart PIN entry
//   DIGITO_STB       in  level digit strobe, new digit on each 0->1 edge
//   DIGITO           in  digit value, sampled in the strobe edge cycle
//   ACCESO_ACEPTADO  out PIN matched (registered)
//   ACCESO_DENEGADO  out PIN mismatch or timeout (registered)
//   BLOQUEO          out lockout active (registered)
//   INTENTOS         out consecutive denials so far (registered, saturating)
// -----------------------------------------------------------------------------
module pin_access_ctrl
  import pin_access_ctrl_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int PIN_LEN        = 4,
  parameter logic [PIN_LEN*DIGIT_W-1:0] PIN_VALUE = 16'h6969,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           SOLICITUD_ACCESO,
  input  logic                           DIGITO_STB,
  input  logic [DIGIT_W-1:0]             DIGITO,
  output logic                           ACCESO_ACEPTADO,
  output logic                           ACCESO_DENEGADO,
  output logic                           BLOQUEO,
  output logic [$clog2(MAX_TRIES+1)-1:0] INTENTOS
);

  localparam int PIN_W = PIN_LEN * DIGIT_W;
  localparam int IDX_W = cnt_width(PIN_LEN);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  // Lockout and timeout never run together, so one counter serves both.
  localparam int CNT_W = cnt_width(max_int(LOCK_CYCLES, TIMEOUT_CYCLES));

  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PIN_LEN - 1);
  localparam logic [TRY_W-1:0] TRY_ZERO  = TRY_W'(0);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);
  localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
`ifdef PIN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_e             state_r, state_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic               mism_r, mism_nxt_s;
  logic [TRY_W-1:0]   tries_r, tries_nxt_s, tries_inc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               acc_r, den_r, blq_r;
  logic               digit_evt_s;
  logic [PIN_W-1:0]   pin_shift_s;
  logic [DIGIT_W-1:0] digit_exp_s;
  logic               digit_bad_s;

  stb_edge_det u_stb_edge_det (
    .clk   (CLK),
    .rst_n (RESET),
    .stb   (DIGITO_STB),
    .evt   (digit_evt_s)
  );

  // Expected digit for the current index: shift it into the MS slice.
  always_comb begin
    pin_shift_s = PIN_VALUE << (idx_r * DIGIT_W);
    digit_exp_s = pin_shift_s[PIN_W-1 -: DIGIT_W];
    digit_bad_s = (DIGITO != digit_exp_s);
    if (tries_r == TRY_MAX) begin
      tries_inc_s = tries_r;
    end else begin
      tries_inc_s = tries_r + TRY_ONE;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    mism_nxt_s  = mism_r;
    tries_nxt_s = tries_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (SOLICITUD_ACCESO) begin
          state_nxt_s = ST_CAPTURE;
          idx_nxt_s   = IDX_ZERO;
          mism_nxt_s  = 1'b0;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // A request in the same cycle as a digit event discards that digit.
        if (SOLICITUD_ACCESO) begin
          idx_nxt_s  = IDX_ZERO;
          mism_nxt_s = 1'b0;
          cnt_nxt_s  = CNT_ZERO;
        end else if (digit_evt_s) begin
          cnt_nxt_s = CNT_ZERO;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s  = IDX_ZERO;
            mism_nxt_s = 1'b0;
            if (mism_r || digit_bad_s) begin
              state_nxt_s = ST_DENIED;
              tries_nxt_s = tries_inc_s;
            end else begin
              state_nxt_s = ST_GRANTED;
              tries_nxt_s = TRY_ZERO;
            end
          end else begin
            idx_nxt_s  = idx_r + IDX_ONE;
            mism_nxt_s = mism_r | digit_bad_s;
          end
`ifdef PIN_TIMEOUT_EN
        end else if (idx_r != IDX_ZERO) begin
          // Only a partially entered PIN can time out.
          if (cnt_r == TO_LAST) begin
            state_nxt_s = ST_DENIED;
            tries_nxt_s = tries_inc_s;
            idx_nxt_s   = IDX_ZERO;
            mism_nxt_s  = 1'b0;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
`endif
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      ST_GRANTED: begin
        if (SOLICITUD_ACCESO) begin
          state_nxt_s = ST_CAPTURE;
          idx_nxt_s   = IDX_ZERO;
          mism_nxt_s  = 1'b0;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_GRANTED;
        end
      end
      ST_DENIED: begin
        // Count already updated on entry; reaching the limit locks next cycle.
        if (tries_r >= TRY_MAX) begin
          state_nxt_s = ST_LOCKED;
          cnt_nxt_s   = CNT_ZERO;
        end else if (SOLICITUD_ACCESO) begin
          state_nxt_s = ST_CAPTURE;
          idx_nxt_s   = IDX_ZERO;
          mism_nxt_s  = 1'b0;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_DENIED;
        end
      end
      ST_LOCKED: begin
        if (cnt_r == LOCK_LAST) begin
          state_nxt_s = ST_IDLE;
          tries_nxt_s = TRY_ZERO;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = IDX_ZERO;
        mism_nxt_s  = 1'b0;
        tries_nxt_s = TRY_ZERO;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers and Moore outputs decoded from the next state, so the
  // outputs change on the same edge as the state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx_r   <= IDX_ZERO;
      mism_r  <= 1'b0;
      tries_r <= TRY_ZERO;
      cnt_r   <= CNT_ZERO;
      acc_r   <= 1'b0;
      den_r   <= 1'b0;
      blq_r   <= 1'b0;
    end else begin
      idx_r   <= idx_nxt_s;
      mism_r  <= mism_nxt_s;
      tries_r <= tries_nxt_s;
      cnt_r   <= cnt_nxt_s;
      acc_r   <= (state_nxt_s == ST_GRANTED);
      den_r   <= (state_nxt_s == ST_DENIED);
      blq_r   <= (state_nxt_s == ST_LOCKED);
    end
  end

  assign ACCESO_ACEPTADO = acc_r;
  assign ACCESO_DENEGADO = den_r;
  assign BLOQUEO         = blq_r;
  assign INTENTOS        = tries_r;

endmodule

// File: tb/tb_pin_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pin_access_ctrl
//   Self-checking bench for pin_access_ctrl with default parameters
//   (PIN 6969, 3 tries, 64-cycle lockout, 32-cycle timeout when
//   PIN_TIMEOUT_EN is defined). Expected outputs are queued when a scenario is
//   driven and compared when the DUT is sampled, #1 after the active edge.
// -----------------------------------------------------------------------------
module tb_pin_access_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SOLICITUD_ACCESO = 1'b0;
  logic       DIGITO_STB = 1'b0;
  logic [3:0] DIGITO = 4'd0;
  logic       ACCESO_ACEPTADO;
  logic       ACCESO_DENEGADO;
  logic       BLOQUEO;
  logic [1:0] INTENTOS;

  int checks = 0;
  int errors = 0;
  int lock_cnt;
  int wait_cnt;

  typedef struct {
    logic       acc;
    logic       den;
    logic       blq;
    logic [1:0] tries;
  } exp_t;

  exp_t sb_q[$];

  pin_access_ctrl dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .SOLICITUD_ACCESO (SOLICITUD_ACCESO),
    .DIGITO_STB       (DIGITO_STB),
    .DIGITO           (DIGITO),
    .ACCESO_ACEPTADO  (ACCESO_ACEPTADO),
    .ACCESO_DENEGADO  (ACCESO_DENEGADO),
    .BLOQUEO          (BLOQUEO),
    .INTENTOS         (INTENTOS)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic a, input logic d, input logic b, input logic [1:0] t);
    exp_t e;
    e.acc = a; e.den = d; e.blq = b; e.tries = t;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check_eq({tag, "_sb_level"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_acc"}, ACCESO_ACEPTADO, e.acc);
      check_eq({tag, "_den"}, ACCESO_DENEGADO, e.den);
      check_eq({tag, "_blq"}, BLOQUEO, e.blq);
      check_eq({tag, "_tries"}, INTENTOS, e.tries);
    end
  endtask

  task automatic req_pulse();
    @(negedge CLK); SOLICITUD_ACCESO = 1'b1;
    @(negedge CLK); SOLICITUD_ACCESO = 1'b0;
  endtask

  // Strobe low for a cycle, then high with the digit; returns #1 after the
  // edge that registers the digit event.
  task automatic digit(input logic [3:0] d);
    @(negedge CLK); DIGITO_STB = 1'b0;
    @(negedge CLK); DIGITO_STB = 1'b1; DIGITO = d;
    @(posedge CLK); #1;
  endtask

  task automatic digits4(input logic [15:0] pin);
    for (int i = 0; i < 4; i++) begin
      digit(pin[15-4*i -: 4]);
    end
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    req_pulse();
    digits4(pin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    push_exp(1'b0, 1'b0, 1'b0, 2'd0);
    pop_check("reset");
    @(negedge CLK); RESET = 1'b1;

    // 1: correct PIN, decision visible right after the 4th event edge
    push_exp(1'b1, 1'b0, 1'b0, 2'd0);
    enter_pin(16'h6969);
    pop_check("t1_grant");

    // 2: two wrong PINs, counter steps
    push_exp(1'b0, 1'b1, 1'b0, 2'd1);
    enter_pin(16'h3969);
    pop_check("t2_deny1");
    push_exp(1'b0, 1'b1, 1'b0, 2'd2);
    enter_pin(16'h6369);
    pop_check("t2_deny2");

    // 3: third wrong PIN -> one denied cycle then lockout
    push_exp(1'b0, 1'b1, 1'b0, 2'd3);
    enter_pin(16'h6968);
    pop_check("t3_deny3");
    @(posedge CLK); #1;
    push_exp(1'b0, 1'b0, 1'b1, 2'd3);
    pop_check("t3_locked");
    lock_cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      SOLICITUD_ACCESO = i[0];
      DIGITO_STB = i[1];
      DIGITO = 4'd6;
      @(posedge CLK); #1;
      if (BLOQUEO) begin
        lock_cnt++;
      end else begin
        break;
      end
    end
    check_eq("t3_lock_len", lock_cnt, 64);
    push_exp(1'b0, 1'b0, 1'b0, 2'd0);
    pop_check("t3_after");
    @(negedge CLK); SOLICITUD_ACCESO = 1'b0;
    // Digits in IDLE without a request are ignored
    push_exp(1'b0, 1'b0, 1'b0, 2'd0);
    digits4(16'h6969);
    pop_check("t3_no_req");

    // 4: async reset mid-entry clears everything
    push_exp(1'b0, 1'b1, 1'b0, 2'd1);
    enter_pin(16'h1111);
    pop_check("t4_pre_deny");
    req_pulse();
    digit(4'd6);
    @(negedge CLK); RESET = 1'b0;
    #1;
    push_exp(1'b0, 1'b0, 1'b0, 2'd0);
    pop_check("t4_rst_async");
    @(negedge CLK); RESET = 1'b1;
    digit(4'd9); digit(4'd6); digit(4'd9);
    push_exp(1'b0, 1'b0, 1'b0, 2'd0);
    pop_check("t4_no_access");
    push_exp(1'b1, 1'b0, 1'b0, 2'd0);
    enter_pin(16'h6969);
    pop_check("t4_fresh");

    // 5: aborted entry is not counted as an attempt
    push_exp(1'b0, 1'b1, 1'b0, 2'd1);
    enter_pin(16'h2222);
    pop_check("t5_deny");
    req_pulse();
    digit(4'd6); digit(4'd9);
    push_exp(1'b0, 1'b1, 1'b0, 2'd2);
    enter_pin(16'h3333);
    pop_check("t5_abort_nocount");
    req_pulse();
    digit(4'd6); digit(4'd9);
    push_exp(1'b1, 1'b0, 1'b0, 2'd0);
    enter_pin(16'h6969);
    pop_check("t5_restart_grant");

    // Request and strobe edge in the same cycle: the digit is discarded
    req_pulse();
    @(negedge CLK); DIGITO_STB = 1'b0;
    @(negedge CLK); SOLICITUD_ACCESO = 1'b1; DIGITO_STB = 1'b1; DIGITO = 4'd6;
    @(negedge CLK); SOLICITUD_ACCESO = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 2'd0);
    digits4(16'h6969);
    pop_check("t5_req_wins");

    // Held request keeps re-arming; digits while held do not count
    @(negedge CLK); SOLICITUD_ACCESO = 1'b1;
    digit(4'd6); digit(4'd9);
    @(negedge CLK); SOLICITUD_ACCESO = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, 2'd0);
    digits4(16'h6969);
    pop_check("t5_held_req");

    // 6: inter-digit timeout
    req_pulse();
    digit(4'd6);
`ifdef PIN_TIMEOUT_EN
    wait_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      wait_cnt++;
      if (ACCESO_DENEGADO) begin
        break;
      end
    end
    check_eq("t6_timeout_cycles", wait_cnt, 32);
    push_exp(1'b0, 1'b1, 1'b0, 2'd1);
    pop_check("t6_timeout_deny");
`else
    wait_cnt = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      wait_cnt++;
    end
    push_exp(1'b0, 1'b0, 1'b0, 2'd0);
    pop_check("t6_no_timeout");
    push_exp(1'b1, 1'b0, 1'b0, 2'd0);
    digit(4'd9); digit(4'd6); digit(4'd9);
    pop_check("t6_late_grant");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
